// File: rtl/data_mem_pipe_if.sv
// Request/response bundle for data_mem_pipe: one load/store request in per cycle,
// one response out per accepted request.
interface data_mem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/data_mem_pipe.sv
// Pipelined byte-steered data memory: clears itself after reset, then accepts one
// load/store per cycle and answers each after a fixed LATENCY.
module data_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic           clk,
  input  logic           rstd,
  data_mem_pipe_if.slave bus
);
  localparam int NL    = DATA_W / 8;
  localparam int OFF_W = $clog2(NL);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int MI_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_reg;
  logic [MI_W-1:0]   ic_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word_reg;

  logic              accept;
  logic              in_init;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  word_idx;
  logic [MI_W-1:0]   mem_idx;
  logic [MI_W-1:0]   wr_idx;
  logic              misaligned;
  logic              size_bad;
  logic              range_bad;
  logic              req_err;
  logic              mem_we;
  logic [NL-1:0]     lane_base;
  logic [NL-1:0]     lane_mask;
  logic [NL-1:0]     lane_we;
  logic [DATA_W-1:0] lane_wd;
  logic [DATA_W-1:0] wdata_sh;

  assign in_init   = (state_reg == ST_INIT);
  assign accept    = bus.req_valid && (state_reg == ST_RUN);
  assign off       = bus.req_addr[OFF_W-1:0];
  assign word_idx  = bus.req_addr[ADDR_W-1:OFF_W];
  assign mem_idx   = MI_W'(word_idx);
  assign size_bad  = (bus.req_size == 2'd3) && (DATA_W == 32);
  assign range_bad = 32'(word_idx) >= 32'(DEPTH);
  assign req_err   = misaligned || size_bad || range_bad;
  assign mem_we    = accept && bus.req_we && !req_err;

  always_comb begin
    case (bus.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase
  end

  always_comb begin
    case (bus.req_size)
      2'd0:    lane_base = NL'(1);
      2'd1:    lane_base = NL'(3);
      2'd2:    lane_base = NL'(15);
      default: lane_base = '1;
    endcase
  end

  assign lane_mask = lane_base << off;
  assign wdata_sh  = bus.req_wdata << {off, 3'b000};
  assign wr_idx    = in_init ? ic_reg : mem_idx;

  // The clear sequence owns the write port while in INIT.
  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      assign lane_we[gi]         = in_init || (mem_we && lane_mask[gi]);
      assign lane_wd[gi*8 +: 8]  = in_init ? 8'h00 : wdata_sh[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (lane_we[i]) begin
        mem[wr_idx][i*8 +: 8] <= lane_wd[i*8 +: 8];
      end
    end
    rd_word_reg <= mem[mem_idx];
  end

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      state_reg <= ST_INIT;
      ic_reg    <= '0;
    end else if (state_reg == ST_INIT) begin
      ic_reg <= ic_reg + MI_W'(1);
      if (ic_reg == MI_W'(DEPTH - 1)) begin
        state_reg <= ST_RUN;
      end
    end
  end

  assign bus.req_ready = (state_reg == ST_RUN);

  logic             s0_valid_reg;
  logic             s0_err_reg;
  logic             s0_load_reg;
  logic [OFF_W-1:0] s0_off_reg;
  logic [1:0]       s0_size_reg;
  logic             s0_uns_reg;

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      s0_valid_reg <= 1'b0;
      s0_err_reg   <= 1'b0;
      s0_load_reg  <= 1'b0;
      s0_off_reg   <= '0;
      s0_size_reg  <= 2'd0;
      s0_uns_reg   <= 1'b0;
    end else begin
      s0_valid_reg <= accept;
      if (accept) begin
        s0_err_reg  <= req_err;
        s0_load_reg <= !bus.req_we && !req_err;
        s0_off_reg  <= off;
        s0_size_reg <= bus.req_size;
        s0_uns_reg  <= bus.req_unsigned;
      end
    end
  end

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] s0_rdata;
  logic              s0_err;

  always_comb begin
    shifted = rd_word_reg >> {s0_off_reg, 3'b000};
    case (s0_size_reg)
      2'd0:    ext = s0_uns_reg ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      2'd1:    ext = s0_uns_reg ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      2'd2:    ext = s0_uns_reg ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: ext = shifted;
    endcase
    s0_rdata = (s0_valid_reg && s0_load_reg) ? ext : '0;
    s0_err   = s0_valid_reg && s0_err_reg;
  end

  // Extra response stages only exist when LATENCY > 1; the array read is the first stage.
  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int PL = LATENCY - 1;
      logic              p_valid_reg [PL];
      logic              p_err_reg   [PL];
      logic [DATA_W-1:0] p_rdata_reg [PL];

      always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
          for (int i = 0; i < PL; i++) begin
            p_valid_reg[i] <= 1'b0;
            p_err_reg[i]   <= 1'b0;
            p_rdata_reg[i] <= '0;
          end
        end else begin
          p_valid_reg[0] <= s0_valid_reg;
          p_err_reg[0]   <= s0_err;
          p_rdata_reg[0] <= s0_rdata;
          for (int i = 1; i < PL; i++) begin
            p_valid_reg[i] <= p_valid_reg[i-1];
            p_err_reg[i]   <= p_err_reg[i-1];
            p_rdata_reg[i] <= p_rdata_reg[i-1];
          end
        end
      end

      assign bus.rsp_valid = p_valid_reg[PL-1];
      assign bus.rsp_err   = p_err_reg[PL-1];
      assign bus.rsp_rdata = p_rdata_reg[PL-1];
    end else begin : g_direct
      assign bus.rsp_valid = s0_valid_reg;
      assign bus.rsp_err   = s0_err;
      assign bus.rsp_rdata = s0_rdata;
    end
  endgenerate
endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: a 32-bit/LATENCY=3 instance and a 64-bit/LATENCY=4 instance
// checked against directed tables and a byte-addressed reference model.
module tb_data_mem_pipe;
  localparam int L32 = 3;
  localparam int D32 = 256;
  localparam int L64 = 4;
  localparam int D64 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32;
  logic rst64;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [10:0] addr;
    logic [63:0] wdata;
    bit          err;
    logic [63:0] rdata;
  } vec_t;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] rdata;
    int          tag;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m32 [D32*4];

  data_mem_pipe_if #(.DATA_W(32), .ADDR_W(11)) b32 ();
  data_mem_pipe_if #(.DATA_W(64), .ADDR_W(10)) b64 ();

  data_mem_pipe #(.DATA_W(32), .DEPTH(D32), .ADDR_W(11), .LATENCY(L32)) u32 (
    .clk(clk), .rstd(rst32), .bus(b32)
  );
  data_mem_pipe #(.DATA_W(64), .DEPTH(D64), .ADDR_W(10), .LATENCY(L64)) u64 (
    .clk(clk), .rstd(rst64), .bus(b64)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(bit we, logic [1:0] sz, bit uns, logic [10:0] a,
                              logic [63:0] wd, bit err, logic [63:0] rd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.err = err; v.rdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Little-endian byte-array view of the 32-bit memory.
  function automatic void model32(input bit we, input logic [1:0] size, input bit uns,
                                  input logic [10:0] addr, input logic [31:0] wdata,
                                  output bit err, output logic [31:0] rdata);
    int n = 1 << size;
    int a = int'(addr);
    err   = ((a % n) != 0) || (size == 2'd3) || ((a / 4) >= D32);
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) m32[a+i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rdata[8*i +: 8] = m32[a+i];
      if (!uns && rdata[8*n-1]) begin
        for (int i = n; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
      end
    end
  endfunction

  task automatic step32(input bit v, input bit we, input logic [1:0] size, input bit uns,
                        input logic [10:0] addr, input logic [31:0] wdata,
                        input bit use_exp, input bit x_err, input logic [31:0] x_rdata,
                        input int tag);
    exp_t        e;
    bit          m_err;
    logic [31:0] m_rd;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check($sformatf("rsp_valid[%0d]", e.tag), 64'(b32.rsp_valid), 64'd1);
      check($sformatf("rsp_err[%0d]", e.tag), 64'(b32.rsp_err), 64'(e.err));
      check($sformatf("rsp_rdata[%0d]", e.tag), 64'(b32.rsp_rdata), 64'(e.rdata));
      $display("rsp32 tag=%0d err=%0b rdata=%h", e.tag, b32.rsp_err, b32.rsp_rdata);
    end else begin
      check($sformatf("idle_valid@%0d", cyc), 64'(b32.rsp_valid), 64'd0);
    end
    b32.req_valid    = v;
    b32.req_we       = we;
    b32.req_size     = size;
    b32.req_unsigned = uns;
    b32.req_addr     = addr;
    b32.req_wdata    = wdata;
    if (v) begin
      check($sformatf("req_ready[%0d]", tag), 64'(b32.req_ready), 64'd1);
      model32(we, size, uns, addr, wdata, m_err, m_rd);
      e.err   = use_exp ? x_err : m_err;
      e.rdata = use_exp ? x_rdata : m_rd;
      e.due   = cyc + L32;
      e.tag   = tag;
      q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
    b32.req_valid = 1'b0;
  endtask

  task automatic drain32(input int n);
    for (int i = 0; i < n; i++) step32(1'b0, 1'b0, 2'd0, 1'b0, 11'd0, 32'd0, 1'b0, 1'b0, 32'd0, -1);
  endtask

  task automatic xfer64(input vec_t t, input int tag);
    int n = 0;
    while (!b64.req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("ready64[%0d]", tag), 64'(b64.req_ready), 64'd1);
    b64.req_valid    = 1'b1;
    b64.req_we       = t.we;
    b64.req_size     = t.size;
    b64.req_unsigned = t.uns;
    b64.req_addr     = t.addr[9:0];
    b64.req_wdata    = t.wdata;
    @(posedge clk); #1;
    b64.req_valid = 1'b0;
    for (int k = 1; k < L64; k++) begin
      check($sformatf("early64[%0d]", tag), 64'(b64.rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    check($sformatf("valid64[%0d]", tag), 64'(b64.rsp_valid), 64'd1);
    check($sformatf("err64[%0d]", tag), 64'(b64.rsp_err), 64'(t.err));
    check($sformatf("rdata64[%0d]", tag), b64.rsp_rdata, t.rdata);
    $display("rsp64 tag=%0d err=%0b rdata=%h", tag, b64.rsp_err, b64.rsp_rdata);
  endtask

  initial begin
    vec_t        tv32[$];
    vec_t        tv64[$];
    int          n;
    bit          rv;
    bit          rwe;
    logic [1:0]  rsz;
    logic [10:0] ra;

    tv32.push_back(mk(0, 2, 0, 11'h3FC, 0,             0, 0));
    tv32.push_back(mk(1, 2, 0, 11'h010, 64'h11223344, 0, 0));
    tv32.push_back(mk(1, 0, 0, 11'h012, 64'hAA,       0, 0));
    tv32.push_back(mk(0, 2, 0, 11'h010, 0,             0, 64'h11AA3344));
    tv32.push_back(mk(0, 0, 0, 11'h012, 0,             0, 64'hFFFFFFAA));
    tv32.push_back(mk(0, 0, 1, 11'h012, 0,             0, 64'h000000AA));
    tv32.push_back(mk(1, 0, 0, 11'h013, 64'h12345678, 0, 0));
    tv32.push_back(mk(0, 2, 1, 11'h010, 0,             0, 64'h78AA3344));
    tv32.push_back(mk(1, 1, 0, 11'h022, 64'h8001,     0, 0));
    tv32.push_back(mk(0, 1, 0, 11'h022, 0,             0, 64'hFFFF8001));
    tv32.push_back(mk(0, 1, 1, 11'h022, 0,             0, 64'h00008001));
    tv32.push_back(mk(0, 1, 0, 11'h021, 0,             1, 0));
    tv32.push_back(mk(1, 2, 0, 11'h400, 64'hDEADBEEF, 1, 0));
    tv32.push_back(mk(1, 2, 0, 11'h402, 64'hDEADBEEF, 1, 0));
    tv32.push_back(mk(0, 3, 0, 11'h020, 0,             1, 0));
    tv32.push_back(mk(1, 3, 0, 11'h020, 64'hFFFFFFFF, 1, 0));
    tv32.push_back(mk(1, 1, 0, 11'h023, 64'hFFFF,     1, 0));
    tv32.push_back(mk(0, 2, 0, 11'h020, 0,             0, 64'h80010000));
    tv32.push_back(mk(0, 2, 0, 11'h000, 0,             0, 64'h00000000));
    tv32.push_back(mk(0, 0, 0, 11'h023, 0,             0, 64'hFFFFFF80));

    tv64.push_back(mk(1, 3, 0, 11'h008, 64'h0123456789ABCDEF, 0, 0));
    tv64.push_back(mk(0, 2, 0, 11'h00C, 0, 0, 64'h0000000001234567));
    tv64.push_back(mk(0, 0, 1, 11'h00F, 0, 0, 64'h0000000000000001));
    tv64.push_back(mk(0, 2, 0, 11'h008, 0, 0, 64'hFFFFFFFF89ABCDEF));
    tv64.push_back(mk(0, 2, 1, 11'h008, 0, 0, 64'h0000000089ABCDEF));
    tv64.push_back(mk(0, 3, 0, 11'h008, 0, 0, 64'h0123456789ABCDEF));
    tv64.push_back(mk(0, 1, 0, 11'h00A, 0, 0, 64'hFFFFFFFFFFFF89AB));
    tv64.push_back(mk(1, 2, 0, 11'h200, 64'h55, 1, 0));
    tv64.push_back(mk(0, 3, 0, 11'h00C, 0, 1, 0));
    tv64.push_back(mk(0, 3, 0, 11'h1F8, 0, 0, 0));
    tv64.push_back(mk(1, 0, 0, 11'h1FF, 64'hA5, 0, 0));
    tv64.push_back(mk(0, 0, 0, 11'h1FF, 0, 0, 64'hFFFFFFFFFFFFFFA5));
    tv64.push_back(mk(0, 3, 0, 11'h1F8, 0, 0, 64'hA500000000000000));
    tv64.push_back(mk(0, 3, 0, 11'h200, 0, 1, 0));

    for (int i = 0; i < D32 * 4; i++) m32[i] = 8'h00;
    b32.req_valid = 0; b32.req_we = 0; b32.req_size = 0; b32.req_unsigned = 0;
    b32.req_addr = 0; b32.req_wdata = 0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_size = 0; b64.req_unsigned = 0;
    b64.req_addr = 0; b64.req_wdata = 0;
    rst32 = 1'b1;
    rst64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(b32.req_ready), 64'd0);
    check("rst_valid", 64'(b32.rsp_valid), 64'd0);
    check("rst_err", 64'(b32.rsp_err), 64'd0);
    check("rst_rdata", 64'(b32.rsp_rdata), 64'd0);
    check("rst_ready64", 64'(b64.req_ready), 64'd0);
    rst32 = 1'b0;
    rst64 = 1'b0;

    // Junk stores while clearing must be ignored.
    n = 0;
    while (!b32.req_ready && n < 1000) begin
      check("init_valid", 64'(b32.rsp_valid), 64'd0);
      b32.req_valid = 1'b1;
      b32.req_we    = 1'b1;
      b32.req_size  = 2'd2;
      b32.req_addr  = 11'($urandom) & 11'h3FC;
      b32.req_wdata = $urandom;
      @(posedge clk); #1;
      n++;
    end
    b32.req_valid = 1'b0;
    check("init_cycles", 64'(n), 64'd256);

    cyc = 0;
    foreach (tv32[i]) begin
      step32(1'b1, tv32[i].we, tv32[i].size, tv32[i].uns, tv32[i].addr, tv32[i].wdata[31:0],
             1'b1, tv32[i].err, tv32[i].rdata[31:0], i);
    end
    drain32(L32 + 1);

    for (int i = 0; i < 5; i++)
      step32(1'b1, 1'b1, 2'd2, 1'b0, 11'(4 * i), 32'(i + 1), 1'b1, 1'b0, 32'd0, 100 + i);
    for (int i = 0; i < 5; i++)
      step32(1'b1, 1'b0, 2'd2, 1'b0, 11'(4 * i), 32'd0, 1'b1, 1'b0, 32'(i + 1), 110 + i);
    step32(1'b1, 1'b1, 2'd2, 1'b0, 11'h000, 32'hCAFEF00D, 1'b1, 1'b0, 32'd0, 120);
    step32(1'b1, 1'b0, 2'd2, 1'b1, 11'h000, 32'd0, 1'b1, 1'b0, 32'hCAFEF00D, 121);
    drain32(L32 + 1);

    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rwe = $urandom_range(0, 1) == 1;
      rsz = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 9) == 0) ? 11'($urandom) : 11'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ra = ra & ~(11'((1 << rsz) - 1));
      step32(rv, rwe, rsz, 1'($urandom), ra, $urandom, 1'b0, 1'b0, 32'd0, 1000 + i);
    end
    drain32(L32 + 1);
    check("queue_empty", 64'(q.size()), 64'd0);

    foreach (tv64[i]) xfer64(tv64[i], 200 + i);

    // Two loads in flight, then a one-cycle reset: nothing may emerge and INIT reruns.
    b64.req_valid    = 1'b1;
    b64.req_we       = 1'b0;
    b64.req_size     = 2'd3;
    b64.req_unsigned = 1'b0;
    b64.req_addr     = 10'h008;
    @(posedge clk); #1;
    b64.req_addr     = 10'h1F8;
    @(posedge clk); #1;
    b64.req_valid    = 1'b0;
    rst64            = 1'b1;
    @(posedge clk); #1;
    rst64            = 1'b0;
    n = 0;
    while (!b64.req_ready && n < 500) begin
      check("flush64", 64'(b64.rsp_valid), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    check("reinit64", 64'(n), 64'd64);
    for (int k = 0; k < L64 + 2; k++) begin
      check("post_flush64", 64'(b64.rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    xfer64(mk(0, 3, 0, 11'h008, 0, 0, 0), 300);
    xfer64(mk(0, 3, 0, 11'h1F8, 0, 0, 0), 301);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised, pipelined data memory that replaces the fixed 8-bit × 4-lane data memory in the `execute` stage. It accepts one load or store per cycle over a valid/ready handshake and performs byte/half/word(/dword) lane steering and load sign/zero extension internally. It returns every response after a fixed, configurable latency. After reset, it clears its whole array to zero before accepting requests.

## Interface
- `DATA_W`, 32: word width in bits; legal values are 32 and 64; lanes `NL = DATA_W/8`.
- `DEPTH`, 256: number of words.
- `ADDR_W`, 10: byte-address width; `OFF_W = log2(NL)`; word index is `req_addr[ADDR_W-1:OFF_W]`.
- `LATENCY`, 1: read pipeline depth in cycles; legal range 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstd`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word (32 bit), 3 = dword (legal only when `DATA_W`=64).
- `req_unsigned`  in  1  load zero-extends when 1; sign-extends when 0.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-justified (the low `8<<size` bits are used).
- `rsp_valid`  out  1  response present (one-cycle pulse per accepted request).
- `rsp_err`  out  1  request was misaligned, had an illegal size, or was out of range.
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores and errors.

## Operation
- **FSM states:** INIT and RUN.
  - `rstd` high forces INIT, sets the clear counter `ic`=0, and flushes the response pipeline.
  - In INIT, word `ic` is written to 0 each cycle and `ic` increments. When `ic`=DEPTH-1 is written, the FSM moves to RUN.
  - RUN persists until the next reset.
- **Ready:** `req_ready` = (state == RUN). A request is accepted when `req_valid && req_ready`.
- **Error conditions:**
  - `req_addr` is not a multiple of `1<<req_size`.
  - `req_size`=3 with `DATA_W`=32.
  - Word index ≥ DEPTH.
  - An errored request never writes memory, and its response has `rsp_rdata`=0.
- **Store:**
  - Byte offset `o = req_addr[OFF_W-1:0]`.
  - Lane mask = `((1<<(1<<size))-1) << o`.
  - Data = `req_wdata << (8*o)`.
  - Only the masked lanes are written, at the accept edge.
- **Load:** read the word, shift right by `8*o`, keep the low `8<<size` bits, then extend per `req_unsigned` to `DATA_W`.
- **Responses:** every accepted request (load, store, or error) produces exactly one response, in request order.

## Timing
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
- **INIT duration:** exactly DEPTH cycles after `rstd` deasserts. `req_ready` rises on the cycle after the last clear write.
- **Response latency:** a request accepted at edge N gives `rsp_valid`=1 during the cycle after edge N+LATENCY-1. With LATENCY=1, the response appears in the cycle immediately following the accept.
- **Throughput:** one request per cycle in RUN with no bubbles; `rsp_valid` may be high on consecutive cycles.
- **Store followed by load:** a store accepted at edge N followed by a load to the same word accepted at edge N+1 returns the new data. There is no hazard stall.
- **Array read timing:** the array is read at the accept edge. Later stores do not affect a load already in flight.
- **Reset mid-operation:**
  - In-flight responses are discarded and no `rsp_valid` is produced for them.
  - A store accepted on the same edge as the reset assertion is not guaranteed.
  - Memory is re-cleared.
- **Requests during INIT:** `req_valid` during INIT is ignored with no side effect.

## Test plan
- **Reset/clear:** with DATA_W=32 and DEPTH=256, hold `rstd` high then release, and count cycles. `req_ready` rises exactly 256 cycles after release. A word load from 0x3FC returns 0x00000000.
- **Word and byte lanes:** store word 0x11223344 at 0x10, store byte 0xAA at 0x12, then load word 0x10 → 0x11AA3344. Signed byte load at 0x12 → 0xFFFFFFAA; unsigned → 0x000000AA.
- **Half extension:** store half 0x8001 at 0x22. Signed half load → 0xFFFF8001; unsigned → 0x00008001.
- **Errors:** each of the following gives `rsp_err`=1, `rsp_rdata`=0, and no memory change:
  - Half load at 0x21.
  - Word store at 0x402 with DEPTH=256.
  - `req_size`=3 with DATA_W=32.
- **Pipelining:** with LATENCY=3, issue 5 back-to-back loads of addresses 0,4,8,12,16 preloaded with 1..5. `rsp_valid` is high for 5 consecutive cycles, beginning 3 cycles after the first accept, with data 1..5 in order. A store to 0 plus a load of 0 on the next cycle returns the stored value.
- **Reset mid-flight:** with LATENCY=4, accept 2 loads, then assert `rstd` for 1 cycle. No `rsp_valid` follows, and INIT restarts for the full DEPTH cycles.
- **DATA_W=64:** dword store 0x0123456789ABCDEF at 0x8, then word load at 0xC → 0x01234567 and byte load at 0xF → 0x00000000_00000001.
